// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the iterative radix-2 restoring divider behind DIV/DIVU in EX.
// Operands are captured from E. The divider runs WIDTH shift/subtract steps, applies the
// sign fix-up, and holds the result while the rest of the pipeline catches up.
// Optional feature: define DIV_EARLY_EXIT_EN to bypass the iteration loop when the
// divisor is zero or when |dividend| < |divisor|.
`timescale 1ns/1ps

module div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             pipe_stall,
    output logic             div_stall,
    output logic             div_valid,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        BUSY = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             aNeg, bNeg;
    logic [WIDTH-1:0] aMag, bMag;
    logic [WIDTH:0]   shifted;
    logic             geq;
    logic [WIDTH-1:0] rSub;

    // Next-state logic: sequencing, one divide step per BUSY cycle, and the sign fix-up
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        bmag_d   = bmag_q;
        q_d      = q_q;
        r_d      = r_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        aNeg    = signed_q & a_q[WIDTH-1];
        bNeg    = signed_q & b_q[WIDTH-1];
        aMag    = aNeg ? (~a_q + 1'b1) : a_q;
        bMag    = bNeg ? (~b_q + 1'b1) : b_q;
        // The partial remainder is always below the divisor magnitude, so it fits in
        // WIDTH bits. After the shift it needs one extra bit.
        shifted = {r_q, q_q[WIDTH-1]};
        geq     = (shifted >= {1'b0, bmag_q});
        rSub    = shifted[WIDTH-1:0] - bmag_q;

        case (state_q)
            IDLE: begin
                if (div_startE && !flushE) begin
                    a_d      = srcaE;
                    b_d      = srcbE;
                    signed_d = div_signedE;
                    state_d  = PREP;
                end
            end
            PREP: begin
                q_d     = aMag;
                bmag_d  = bMag;
                r_d     = '0;
                qneg_d  = aNeg ^ bNeg;
                rneg_d  = aNeg;
                cnt_d   = '0;
                state_d = BUSY;
`ifdef DIV_EARLY_EXIT_EN
                if ((b_q == '0) || (aMag < bMag)) begin
                    q_d     = '0;
                    r_d     = aMag;
                    state_d = FIX;
                end
`endif
            end
            BUSY: begin
                r_d   = geq ? rSub : shifted[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], geq};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (b_q == '0) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = qneg_q ? (~q_q + 1'b1) : q_q;
                    hi_d = rneg_q ? (~r_q + 1'b1) : r_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (!pipe_stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush cancels everything in flight but leaves the last published result alone
        if (flushE) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            bmag_q   <= '0;
            q_q      <= '0;
            r_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            bmag_q   <= bmag_d;
            q_q      <= q_d;
            r_q      <= r_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Stall the pipeline from the cycle the start is seen until the result is fixed up
    always_comb begin
        div_stall = !flushE && (((state_q == IDLE) && div_startE) ||
                                (state_q == PREP) || (state_q == BUSY) || (state_q == FIX));
        div_valid = !flushE && (state_q == DONE);
    end

    assign div_hi = hi_q;
    assign div_lo = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl.
// The bench uses directed corner cases plus random divides. Results are checked
// against an arithmetic reference model built from longint division.
`timescale 1ns/1ps

module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        div_startE;
    logic        div_signedE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        pipe_stall;
    logic        div_stall;
    logic        div_valid;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    int assertCount = 0;
    int failCount   = 0;

    div_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_startE (div_startE),
        .div_signedE(div_signedE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .flushE     (flushE),
        .pipe_stall (pipe_stall),
        .div_stall  (div_stall),
        .div_valid  (div_valid),
        .div_hi     (div_hi),
        .div_lo     (div_lo)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model: quotient/remainder from plain arithmetic, plus the expected latency
    function automatic void refDivide(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                      output logic [31:0] lo, output logic [31:0] hi, output int lat);
        longint na, nb, q, r;
        logic [63:0] q64, r64;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else begin
            na  = sgn ? longint'($signed(a)) : longint'(a);
            nb  = sgn ? longint'($signed(b)) : longint'(b);
            q   = na / nb;
            r   = na % nb;
            q64 = q;
            r64 = r;
            lo  = q64[31:0];
            hi  = r64[31:0];
        end
        lat = 35;
`ifdef DIV_EARLY_EXIT_EN
        begin
            longint ma, mb;
            ma = sgn ? longint'($signed(a)) : longint'(a);
            mb = sgn ? longint'($signed(b)) : longint'(b);
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
            if ((b == 32'd0) || (ma < mb)) lat = 3;
        end
`endif
    endfunction

    // Run one divide from an IDLE negedge through DONE and back to IDLE
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int holdCycles);
        logic [31:0] expLo, expHi, prevLo, prevHi;
        int          lat, cyc;
        logic        stallOk, stableOk;
        refDivide(a, b, sgn, expLo, expHi, lat);
        prevLo      = div_lo;
        prevHi      = div_hi;
        div_startE  = 1'b1;
        div_signedE = sgn;
        srcaE       = a;
        srcbE       = b;
        stallOk     = 1'b1;
        stableOk    = 1'b1;
        cyc         = 0;
        #1;
        while (!div_valid && cyc < 60) begin
            if (div_stall !== 1'b1) stallOk = 1'b0;
            if (div_lo !== prevLo || div_hi !== prevHi) stableOk = 1'b0;
            @(negedge clk);
            cyc++;
            div_startE = 1'b0;
            srcaE      = $urandom;
            srcbE      = $urandom;
        end
        checkOutput("latency", 32'(cyc), 32'(lat));
        checkOutput("stallWindow", {31'd0, stallOk}, 32'd1);
        checkOutput("hiLoStable", {31'd0, stableOk}, 32'd1);
        checkOutput("lo", div_lo, expLo);
        checkOutput("hi", div_hi, expHi);
        checkOutput("stallInDone", {31'd0, div_stall}, 32'd0);
        pipe_stall = (holdCycles > 0);
        for (int i = 0; i < holdCycles; i++) begin
            div_startE = 1'b1;
            @(negedge clk);
            if (i == holdCycles - 1) begin
                pipe_stall = 1'b0;
                div_startE = 1'b0;
            end
            checkOutput("heldValid", {31'd0, div_valid}, 32'd1);
            checkOutput("heldLo", div_lo, expLo);
            checkOutput("heldHi", div_hi, expHi);
            checkOutput("heldStall", {31'd0, div_stall}, 32'd0);
        end
        div_startE = 1'b0;
        @(negedge clk);
        checkOutput("idleValid", {31'd0, div_valid}, 32'd0);
        checkOutput("idleStall", {31'd0, div_stall}, 32'd0);
        checkOutput("idleLo", div_lo, expLo);
    endtask

    // Main sequence: reset, directed corners, flush, reset mid-op, random divides
    initial begin
        logic [31:0] ra, rb, keepLo, keepHi;
        int sel;
        rst         = 1'b1;
        div_startE  = 1'b0;
        div_signedE = 1'b0;
        srcaE       = '0;
        srcbE       = '0;
        flushE      = 1'b0;
        pipe_stall  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstValid", {31'd0, div_valid}, 32'd0);
        checkOutput("rstStall", {31'd0, div_stall}, 32'd0);
        checkOutput("rstHi", div_hi, 32'd0);
        checkOutput("rstLo", div_lo, 32'd0);

        applyStimulus(32'd100, 32'd7, 1'b0, 0);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        applyStimulus(32'd5, 32'd0, 1'b0, 0);
        applyStimulus(32'hFFFF_FFF0, 32'd0, 1'b1, 0);
        applyStimulus(32'd3, 32'd5, 1'b0, 3);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 0);

        // Flush on the 10th BUSY cycle, then restart immediately
        keepLo      = div_lo;
        keepHi      = div_hi;
        div_startE  = 1'b1;
        div_signedE = 1'b0;
        srcaE       = 32'd1000;
        srcbE       = 32'd3;
        @(negedge clk);
        div_startE = 1'b0;
        repeat (10) @(negedge clk);
        flushE = 1'b1;
        #1;
        checkOutput("flushStall", {31'd0, div_stall}, 32'd0);
        checkOutput("flushValid", {31'd0, div_valid}, 32'd0);
        @(negedge clk);
        flushE = 1'b0;
        #1;
        checkOutput("postFlushStall", {31'd0, div_stall}, 32'd0);
        checkOutput("postFlushValid", {31'd0, div_valid}, 32'd0);
        checkOutput("postFlushLo", div_lo, keepLo);
        checkOutput("postFlushHi", div_hi, keepHi);
        applyStimulus(32'd1000, 32'd3, 1'b0, 0);

        // A start coinciding with a flush must not launch a divide
        div_startE = 1'b1;
        flushE     = 1'b1;
        #1;
        checkOutput("flushStartStall", {31'd0, div_stall}, 32'd0);
        @(negedge clk);
        div_startE = 1'b0;
        flushE     = 1'b0;
        #1;
        checkOutput("flushStartIdle", {31'd0, div_stall}, 32'd0);

        // Reset in the middle of a divide
        div_startE = 1'b1;
        srcaE      = 32'd77;
        srcbE      = 32'd4;
        @(negedge clk);
        div_startE = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstStall", {31'd0, div_stall}, 32'd0);
        checkOutput("midRstValid", {31'd0, div_valid}, 32'd0);
        checkOutput("midRstLo", div_lo, 32'd0);
        checkOutput("midRstHi", div_hi, 32'd0);

        for (int n = 0; n < 24; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = $urandom_range(1, 15);
            else if (sel == 2) rb = 32'hFFFF_FFFF;
            else if (sel == 3) ra = $urandom_range(0, 1000);
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
